// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce bank: per-channel FSM state encoding
// and helpers for counter sizing and state-to-level decoding.
package debounce_pkg;

  // Two-bit state encoding; bit 1 set means the accepted level is high.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } deb_state_t;

  // Counter width able to hold the value STABLE_CYCLES without wrapping.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

  // Accepted level implied by a state: high in STABLE_HI and WAIT_LO.
  function automatic logic level_of(input deb_state_t st);
    return (st == STABLE_HI) || (st == WAIT_LO);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: optional two-flop synchroniser, four-state FSM with
// a stability counter, and registered level / rise / fall outputs.
// Build option: define DEBOUNCE_BANK_SYNC_EN to place a two-flop
// synchroniser in front of the FSM (adds two cycles of latency).
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 1_000_000,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisy,
  output logic debounced,
  output logic rise,
  output logic fall
);

  localparam int            CW    = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam deb_state_t    RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic          s;
  deb_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          level;

`ifdef DEBOUNCE_BANK_SYNC_EN
  logic sync1, sync2;

  // Two-flop synchroniser; both stages come out of reset at the idle level
  // so no false transition is seen after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
    end else begin
      // NOTE: non-blocking assignments let sync2 capture the old sync1, giving
      // a true two-stage pipeline instead of collapsing into one flop.
      sync1 <= noisy;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = noisy;
`endif

  // Next-state and counter logic; a level change is accepted only after
  // STABLE_CYCLES+1 consecutive samples of the new level.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred for the "hold" cases.
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      STABLE_LO: begin
        if (s) begin
          state_next = WAIT_HI;
          cnt_next   = ONE;
        end else begin
          cnt_next   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
        end else if (cnt >= LIMIT) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt + ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_next = WAIT_LO;
          cnt_next   = ONE;
        end else begin
          cnt_next   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
        end else if (cnt >= LIMIT) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt + ONE;
        end
      end
      default: begin
        state_next = RESET_STATE;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM state and counter registers; reset abandons any count in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RESET_STATE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  assign level = level_of(state);

  // Registered outputs; edge pulses fire in the cycle the output level flips.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: debounced resets to the same level the FSM implies, so nothing
      // looks like an edge when reset is released.
      debounced <= RESET_LEVEL;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      debounced <= level;
      rise      <= level & ~debounced;
      fall      <= ~level & debounced;
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of CHANNELS independent debouncers for switch and button inputs.
// Build option: DEBOUNCE_BANK_SYNC_EN adds a two-flop synchroniser per
// channel for inputs that are asynchronous to clk.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   CHANNELS      = 4,
  parameter int   STABLE_CYCLES = 1_000_000,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  // One self-contained channel per input bit; channels share only the clock.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_LEVEL   (RESET_LEVEL)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .noisy     (noisy[i]),
      .debounced (debounced[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with CHANNELS=4, STABLE_CYCLES=8.
// Expected timings shift by two cycles when DEBOUNCE_BANK_SYNC_EN is defined.
module tb_debounce_bank;

  localparam int CH  = 4;
  localparam int SC  = 8;
`ifdef DEBOUNCE_BANK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk;
  logic          reset_n;
  logic [CH-1:0] noisy;
  logic [CH-1:0] debounced;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  int n_total = 0;
  int n_pass  = 0;
  logic [CH-1:0] rise_acc;
  logic [CH-1:0] fall_acc;

  debounce_bank #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (SC),
    .RESET_LEVEL   (1'b0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .noisy     (noisy),
    .debounced (debounced),
    .rise      (rise),
    .fall      (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Advance n rising edges, sampling 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rise_and_fall_exclusive", 32'(rise & fall), 32'd0);
      rise_acc |= rise;
      fall_acc |= fall;
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    noisy    = '0;
    rise_acc = '0;
    fall_acc = '0;

    // Reset state.
    step(3);
    check("reset_debounced", 32'(debounced), 32'd0);
    check("reset_rise", 32'(rise), 32'd0);
    check("reset_fall", 32'(fall), 32'd0);
    reset_n = 1'b1;

    // Channel 0 accepted after 9 samples; output one edge later.
    noisy    = 4'b0001;
    rise_acc = '0;
    step(SC + 1 + LAT);
    check("ch0_before_accept_deb", 32'(debounced), 32'd0);
    check("ch0_before_accept_rise", 32'(rise_acc), 32'd0);
    step(1);
    check("ch0_accept_deb", 32'(debounced), 32'b0001);
    check("ch0_accept_rise", 32'(rise), 32'b0001);
    step(1);
    check("ch0_rise_one_cycle", 32'(rise), 32'd0);
    check("ch0_held_deb", 32'(debounced), 32'b0001);
    check("ch0_no_fall", 32'(fall_acc), 32'd0);

    // Channel 1 glitches of 8 samples, repeated 5 times: never accepted.
    rise_acc = '0;
    for (int g = 0; g < 5; g++) begin
      noisy = 4'b0011;
      step(SC);
      noisy = 4'b0001;
      step(4);
      check("glitch_cnt_cleared", 32'(dut.g_chan[1].u_chan.cnt), 32'd0);
      check("glitch_deb", 32'(debounced), 32'b0001);
    end
    check("glitch_no_rise", 32'(rise_acc), 32'd0);

    // Bring channel 0 back low.
    noisy    = 4'b0000;
    fall_acc = '0;
    step(SC + 1 + LAT);
    check("ch0_before_fall", 32'(fall_acc), 32'd0);
    step(1);
    check("ch0_fall", 32'(fall), 32'b0001);
    check("ch0_fall_deb", 32'(debounced), 32'd0);
    step(10);

    // All channels together: rise, then fall.
    noisy    = 4'b1111;
    rise_acc = '0;
    step(SC + 1 + LAT);
    check("all_before_rise", 32'(rise_acc), 32'd0);
    step(1);
    check("all_rise", 32'(rise), 32'b1111);
    check("all_rise_deb", 32'(debounced), 32'b1111);
    step(1);
    check("all_rise_done", 32'(rise), 32'd0);
    step(18);
    noisy    = 4'b0000;
    fall_acc = '0;
    step(SC + 1 + LAT);
    check("all_before_fall", 32'(fall_acc), 32'd0);
    check("all_hold_deb", 32'(debounced), 32'b1111);
    step(1);
    check("all_fall", 32'(fall), 32'b1111);
    check("all_fall_deb", 32'(debounced), 32'd0);
    step(1);
    check("all_fall_done", 32'(fall), 32'd0);
    step(18);

    // Reset mid-count on channel 2 abandons the count without a pulse.
    noisy    = 4'b0100;
    rise_acc = '0;
    step(5 + LAT);
    check("mid_cnt_before_reset", 32'(dut.g_chan[2].u_chan.cnt), 32'd5);
    reset_n = 1'b0;
    #2;
    check("mid_reset_cnt", 32'(dut.g_chan[2].u_chan.cnt), 32'd0);
    check("mid_reset_deb", 32'(debounced), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(SC + 1 + LAT);
    check("post_reset_no_rise", 32'(rise_acc), 32'd0);
    check("post_reset_deb_low", 32'(debounced), 32'd0);
    step(1);
    check("post_reset_rise", 32'(rise), 32'b0100);
    check("post_reset_deb", 32'(debounced), 32'b0100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
